// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter feeding a single APB master sequencer (IDLE/SETUP/ACCESS).
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_rr_master_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    output logic [NUM_REQ-1:0]              o_req_ready,
    input  logic [NUM_REQ-1:0]              i_req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_wdata,
    output logic [NUM_REQ-1:0]              o_rsp_valid,
    output logic [DATA_WIDTH-1:0]           o_rsp_rdata,
    output logic                            o_rsp_err,
    output logic                            o_busy,
    output logic                            o_psel,
    output logic                            o_penable,
    output logic                            o_pwrite,
    output logic [ADDR_WIDTH-1:0]           o_paddr,
    output logic [DATA_WIDTH-1:0]           o_pwdata,
    input  logic                            i_pready,
    input  logic [DATA_WIDTH-1:0]           i_prdata,
    input  logic                            i_pslverr
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t                 state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       grant;
    logic [PTR_W-1:0]       winner;
    logic [PTR_W-1:0]       offset;
    logic [PTR_W:0]         sum;
    logic [NUM_REQ-1:0]     rotated;
    logic                   any_valid;
    logic                   sel_write;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0]        to_cnt;
`endif

    // Rotate valids so the pointer position is bit 0, take the lowest set bit,
    // then rotate the offset back into an absolute requester index.
    always_comb begin
        rotated   = NUM_REQ'({i_req_valid, i_req_valid} >> rr_ptr);
        any_valid = 1'b0;
        offset    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_valid && rotated[i]) begin
                any_valid = 1'b1;
                offset    = PTR_W'(i);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (sum >= (PTR_W+1)'(NUM_REQ)) begin
            sum = sum - (PTR_W+1)'(NUM_REQ);
        end
        winner = sum[PTR_W-1:0];
    end

    always_comb begin
        sel_write = i_req_write[winner];
        sel_addr  = i_req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = i_req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
    end

    // Ready is masked during reset so no requester sees an accept that never happens.
    always_comb begin
        o_req_ready = '0;
        if (state == IDLE && any_valid && !i_reset) begin
            o_req_ready = NUM_REQ'(1) << winner;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            o_psel      <= 1'b0;
            o_penable   <= 1'b0;
            o_pwrite    <= 1'b0;
            o_paddr     <= '0;
            o_pwdata    <= '0;
            o_rsp_valid <= '0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            o_busy      <= 1'b0;
`ifdef APB_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            o_rsp_valid <= '0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        state     <= SETUP;
                        grant     <= winner;
                        rr_ptr    <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
                        o_psel    <= 1'b1;
                        o_penable <= 1'b0;
                        o_busy    <= 1'b1;
                        o_pwrite  <= sel_write;
                        o_paddr   <= sel_addr;
                        o_pwdata  <= sel_write ? sel_wdata : '0;
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    o_penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    to_cnt    <= '0;
`endif
                end
                ACCESS: begin
                    if (i_pready) begin
                        state       <= IDLE;
                        o_psel      <= 1'b0;
                        o_penable   <= 1'b0;
                        o_busy      <= 1'b0;
                        o_rsp_valid <= NUM_REQ'(1) << grant;
                        o_rsp_rdata <= o_pwrite ? '0 : i_prdata;
                        o_rsp_err   <= i_pslverr;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state       <= IDLE;
                        o_psel      <= 1'b0;
                        o_penable   <= 1'b0;
                        o_busy      <= 1'b0;
                        o_rsp_valid <= NUM_REQ'(1) << grant;
                        o_rsp_rdata <= '0;
                        o_rsp_err   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state     <= IDLE;
                    o_psel    <= 1'b0;
                    o_penable <= 1'b0;
                    o_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/apb_rr_master_arbiter.md
Name: apb_rr_master_arbiter

Overview:
- Round-robin arbiter and APB master sequencer.
- Lets NUM_REQ independent requesters (register-access engines, debug port, DMA config) share one APB bus driving apb_wrapper-class slaves.
- Latches one request per transfer, runs the APB SETUP/ACCESS protocol, and returns read data and error status to the granted requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width.
- TIMEOUT_CYCLES, 256, ACCESS-phase wait limit; used only with APB_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_req_valid  in  NUM_REQ  per-requester request valid; held with payload until accepted.
- o_req_ready  out  NUM_REQ  accept strobe; one-hot or zero.
- i_req_write  in  NUM_REQ  1=write, 0=read.
- i_req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- i_req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- o_rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- o_rsp_rdata  out  DATA_WIDTH  read data; valid with o_rsp_valid; shared across requesters.
- o_rsp_err  out  1  PSLVERR (or timeout) status; valid with o_rsp_valid.
- o_busy  out  1  high in SETUP or ACCESS.
- o_psel  out  1  APB select.
- o_penable  out  1  APB enable.
- o_pwrite  out  1  APB direction.
- o_paddr  out  ADDR_WIDTH  APB address.
- o_pwdata  out  DATA_WIDTH  APB write data.
- i_pready  in  1  APB ready.
- i_prdata  in  DATA_WIDTH  APB read data.
- i_pslverr  in  1  APB slave error.

Behaviour:
Reset values (i_reset sampled high at an edge):
- State = IDLE; round-robin pointer = 0 (requester 0 highest priority).
- All outputs 0: o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_busy.
- o_req_ready is combinational and therefore 0 in reset.

FSM states IDLE, SETUP, ACCESS:
- IDLE, arbitration: if any i_req_valid bit is set, the winner is the first set bit searching upward, wrapping from the pointer.
- IDLE, accept: o_req_ready[winner]=1 combinationally in the same cycle. At that edge the block latches write/addr/wdata and the grant index, and moves to SETUP. The pointer becomes winner+1 mod NUM_REQ.
- IDLE with no valid: o_req_ready=0, stay in IDLE.
- SETUP: o_psel=1, o_penable=0, paddr/pwrite/pwdata from the latch. o_pwdata=0 for reads. Always exactly one cycle, then ACCESS.
- ACCESS: o_psel=1, o_penable=1, all APB outputs held stable. Stay while i_pready=0 (no limit unless the optional feature is on).
- ACCESS with i_pready=1: at that edge register i_prdata (reads only; writes return 0) and i_pslverr. Next cycle is IDLE with o_rsp_valid[grant]=1 for exactly one cycle, o_psel=0 and o_penable=0.

Timing and ordering:
- Minimum latency is 3 cycles from acceptance edge to o_rsp_valid: SETUP, ACCESS with immediate pready, then the rsp cycle.
- The rsp cycle is also an IDLE arbitration cycle, so a new request may be accepted while o_rsp_valid pulses. Back-to-back throughput is one transfer per 3 cycles.
- o_psel drops for at least one cycle between transfers.

Boundary conditions:
- Simultaneous valids: round-robin, no starvation. Any waiting requester is served within NUM_REQ transfers.
- i_req_valid dropped before ready: the request is ignored; no protocol error is flagged.
- Payload is sampled only at the acceptance edge. Later changes have no effect on the bus.
- Reset mid-transfer (SETUP or ACCESS): next state IDLE, o_psel and o_penable low, pointer = 0. The aborted transfer produces no o_rsp_valid.
- i_pready or i_pslverr outside ACCESS is ignored.
- o_rsp_err is reported only with o_rsp_valid; otherwise 0.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined: an ACCESS-cycle counter counts from 0. If i_pready is still 0 when the count reaches TIMEOUT_CYCLES-1, the transfer ends: next cycle IDLE, psel and penable low, o_rsp_valid pulses with o_rsp_err=1 and o_rsp_rdata=0. The counter clears on entering ACCESS and on reset.
- Not defined: no counter; ACCESS waits for i_pready indefinitely and the TIMEOUT_CYCLES parameter is unused.

Test Plan:
- Single write: req0 write addr 0x44A0_0000 data 0x0123, pready high immediately. Expect SETUP then ACCESS with paddr=0x44A0_0000, pwdata=0x0123, pwrite=1. o_rsp_valid[0] pulses 3 cycles after accept, err=0.
- Read with wait states: req1 read 0x44A0_000C, pready low 4 ACCESS cycles then high with prdata=0x1234. Expect APB outputs stable throughout. o_rsp_valid[1]=1 with rdata=0x1234 on the cycle after pready.
- Contention: req0 and req1 both valid continuously for 4 transfers after reset. Grant order 0,1,0,1. Each transfer 3 cycles apart. psel low one cycle between transfers.
- Slave error: req0 write, pslverr=1 with pready. Expect o_rsp_err=1 with o_rsp_valid[0] and rdata=0.
- Reset mid-ACCESS: assert i_reset during the 2nd wait cycle. Next cycle psel=0, penable=0, no rsp_valid. Next request after reset granted to requester 0 first.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES=8: pready held low. Transfer ends after 8 ACCESS cycles; o_rsp_valid pulses with err=1 and rdata=0.
